// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and defaults for iter_alu
package alu_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_OPW = 5;
    typedef enum logic [DEF_OPW-1:0] {
        OP_ADD = DEF_OPW'(0),
        OP_SUB = DEF_OPW'(1),
        OP_MUL = DEF_OPW'(2),
        OP_DIV = DEF_OPW'(3),
        OP_XOR = DEF_OPW'(4),
        OP_AND = DEF_OPW'(5),
        OP_OR  = DEF_OPW'(6),
        OP_REM = DEF_OPW'(7),
        OP_NOT = DEF_OPW'(8)
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_MUL_ITER, S_DIV_ITER, S_DONE} state_e;
    typedef enum logic {MD_MUL, MD_DIV} md_mode_e;
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: shared bit-serial engine, shift-add multiply and restoring divide
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_mode_e         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [CW-1:0] count;
    md_mode_e mode_q;
    logic [WIDTH-1:0] acc, sh, mc, acc_n, sh_n, mc_n;
    logic [WIDTH:0] rs, diff;
    // one iteration step: acc is accumulator/partial remainder, sh is multiplier/dividend-quotient, mc is multiplicand/divisor
    always_comb begin
        rs = {acc, sh[WIDTH-1]};
        diff = rs - {1'b0, mc};
        acc_n = mode_q == MD_MUL ? (sh[0] ? acc + mc : acc)
                                 : (diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0]);
        sh_n = mode_q == MD_MUL ? sh >> 1 : {sh[WIDTH-2:0], ~diff[WIDTH]};
        mc_n = mode_q == MD_MUL ? mc << 1 : mc;
    end
    assign done = count == CW'(1);
    assign product = acc_n;
    assign quotient = sh_n;
    assign remainder = acc_n;
    // load on start, then step once per edge until the counter drains
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            mode_q <= MD_MUL;
            acc <= '0;
            sh <= '0;
            mc <= '0;
        end else if (start) begin
            count <= CW'(WIDTH);
            mode_q <= mode;
            acc <= '0;
            sh <= mode == MD_MUL ? b : a;
            mc <= mode == MD_MUL ? a : b;
        end else if (count != '0) begin
            count <= count - 1'b1;
            acc <= acc_n;
            sh <= sh_n;
            mc <= mc_n;
        end
    end
endmodule

// File: rtl/iter_alu.sv
// iter_alu: handshaked ALU with single-cycle logic/add ops and iterative MUL/DIV/REM
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW = DEF_OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    state_e state, state_n;
    logic rem_q, rem_n, start, md_done, is_mul, is_div, is_rem, div0;
    md_mode_e mode;
    logic [WIDTH-1:0] sc, res_n, product, quotient, remainder;
    iter_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .a(value1),
        .b(value2),
        .done(md_done),
        .product(product),
        .quotient(quotient),
        .remainder(remainder)
    );
    assign is_mul = opcode == OPW'(OP_MUL);
    assign is_div = opcode == OPW'(OP_DIV);
    assign is_rem = opcode == OPW'(OP_REM);
    assign div0 = value2 == '0;
    assign in_ready = state == S_IDLE;
    assign out_valid = state == S_DONE;
    // single-cycle result; DIV here only occurs for a zero divisor, REM and unknown opcodes pass value1
    always_comb begin
        sc = opcode == OPW'(OP_ADD) ? value1 + value2 :
             opcode == OPW'(OP_SUB) ? value1 - value2 :
             opcode == OPW'(OP_XOR) ? value1 ^ value2 :
             opcode == OPW'(OP_AND) ? value1 & value2 :
             opcode == OPW'(OP_OR)  ? value1 | value2 :
             opcode == OPW'(OP_NOT) ? ~value1 :
             is_div                 ? '1 : value1;
    end
    // next state, engine start and result update
    always_comb begin
        state_n = state;
        res_n = result;
        rem_n = rem_q;
        start = 1'b0;
        mode = MD_MUL;
        case (state)
            S_IDLE: if (in_valid) begin
                rem_n = is_rem;
                if (is_mul) begin
                    start = 1'b1;
                    state_n = S_MUL_ITER;
                end else if ((is_div || is_rem) && !div0) begin
                    start = 1'b1;
                    mode = MD_DIV;
                    state_n = S_DIV_ITER;
                end else begin
                    res_n = sc;
                    state_n = S_DONE;
                end
            end
            S_MUL_ITER: if (md_done) begin
                res_n = product;
                state_n = S_DONE;
            end
            S_DIV_ITER: if (md_done) begin
                res_n = rem_q ? remainder : quotient;
                state_n = S_DONE;
            end
            default: if (out_ready) state_n = S_IDLE;
        endcase
    end
    // state, captured REM flag and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rem_q <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            rem_q <= rem_n;
            result <= res_n;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vectors with a result scoreboard for iter_alu
module tb_iter_alu;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready;
    logic [4:0] opcode;
    logic [63:0] value1, value2, result;
    logic [63:0] exp_q[$];
    string nm_q[$];
    string mn;
    logic [63:0] me;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(64), .OPW(5)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode(opcode),
        .value1(value1),
        .value2(value2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // scoreboard monitor: pops one expectation per completed handshake
    always @(negedge clk) begin
        #1;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got %h want none", result);
            end else begin
                mn = nm_q.pop_front();
                me = exp_q.pop_front();
                chk(mn, result, me);
            end
        end
    end

    // lat = edges after the accept edge until out_valid is visible
    task automatic issue(input string nm, input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] want, input int lat);
        int n;
        logic busy_ok;
        chk({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
        exp_q.push_back(want);
        nm_q.push_back(nm);
        opcode = op;
        value1 = a;
        value2 = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        opcode = 5'd0;
        value1 = ~a;
        value2 = b ^ 64'h5A;
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        if (lat > 0) chk({nm, " busy"}, {63'd0, busy_ok}, 64'd1);
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic stayed_low;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        opcode = 5'd0;
        value1 = '0;
        value2 = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        issue("add", 5'd0, 64'd5, 64'd7, 64'd12, 0);
        issue("sub_wrap", 5'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        issue("mul", 5'd2, 64'hFFFF_FFFF, 64'h10, 64'hF_FFFF_FFF0, 64);
        issue("mul_wrap", 5'd2, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64);
        issue("mul_dec", 5'd2, 64'd12345, 64'd678, 64'd8369910, 64);
        issue("div", 5'd3, 64'd100, 64'd7, 64'd14, 64);
        issue("rem", 5'd7, 64'd100, 64'd7, 64'd2, 64);
        issue("div_big", 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 64);
        issue("rem_exact", 5'd7, 64'd10, 64'd10, 64'd0, 64);
        issue("div0", 5'd3, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        issue("rem0", 5'd7, 64'd9, 64'd0, 64'd9, 0);
        issue("xor", 5'd4, 64'hF0F0, 64'h0FF0, 64'hFF00, 0);
        issue("and", 5'd5, 64'hF0F0, 64'h0FF0, 64'h00F0, 0);
        issue("or", 5'd6, 64'hF0F0, 64'h0FF0, 64'hFFF0, 0);
        issue("not", 5'd8, 64'd5, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        issue("pass9", 5'd9, 64'hDEAD, 64'hBEEF, 64'hDEAD, 0);
        issue("pass31", 5'd31, 64'h1234_5678, 64'd1, 64'h1234_5678, 0);
        out_ready = 1'b0;
        issue("bp_add", 5'd0, 64'd3, 64'd4, 64'd7, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp result", result, 64'd7);
            in_valid = i == 1;
            opcode = 5'd0;
            value1 = 64'd100;
            value2 = 64'd100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp after out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp after in_ready", {63'd0, in_ready}, 64'd1);
        opcode = 5'd3;
        value1 = 64'd1000;
        value2 = 64'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_reset result", result, 64'd0);
        stayed_low = 1'b1;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) stayed_low = 1'b0;
        end
        chk("mid_reset no output", {63'd0, stayed_low}, 64'd1);
        issue("add_after_reset", 5'd0, 64'd1, 64'd1, 64'd2, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
